// File: rtl/acc_collector.sv
// Lane-wise burst accumulator: sums LEN beats of ACC_DATA; result valid 1 cycle after last beat, held until OUT_READY.
// IN_READY only in ACCUM, drops once the burst completes. ACC_COLLECTOR_SAT_EN selects signed saturating lane adds.
module acc_collector #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int LEN_W  = 8
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic [LEN_W-1:0]          LEN,
  input  logic                      ABORT,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [LANES*DATA_W-1:0]   ACC_DATA,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [LANES*DATA_W-1:0]   RESULT,
  output logic [LEN_W-1:0]          BEAT_CNT,
  output logic                      BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                    state_q;
  state_t                    state_nxt;
  logic [DATA_W-1:0]         acc_q   [LANES];
  logic [DATA_W-1:0]         sum_nxt [LANES];
  logic [LANES*DATA_W-1:0]   sum_flat;
  logic [LANES*DATA_W-1:0]   result_q;
  logic [LEN_W-1:0]          beat_cnt_q;
  logic [LEN_W-1:0]          cnt_inc;
  logic [LEN_W-1:0]          len_q;
  logic                      start_ok;
  logic                      beat;
  logic                      last_beat;

  function automatic logic [DATA_W-1:0] lane_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] s;
    s = a + b;
`ifdef ACC_COLLECTOR_SAT_EN
    // Same-sign operands producing an opposite-sign sum means signed overflow.
    if ((a[DATA_W-1] == b[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1])) begin
      s = a[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // Handshake signals decode straight from the state register, so they are glitch-free and reset with it.
  assign IN_READY  = (state_q == S_ACCUM);
  assign OUT_VALID = (state_q == S_HOLD);
  assign BUSY      = (state_q != S_IDLE);
  assign RESULT    = result_q;
  assign BEAT_CNT  = beat_cnt_q;

  assign start_ok  = START && (LEN != '0);
  assign beat      = IN_VALID && IN_READY && !ABORT;
  assign cnt_inc   = beat_cnt_q + 1'b1;
  assign last_beat = beat && (cnt_inc == len_q);

  always_comb begin
    sum_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_nxt[i] = lane_add(acc_q[i], ACC_DATA[i*DATA_W +: DATA_W]);
      sum_flat[i*DATA_W +: DATA_W] = sum_nxt[i];
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (ABORT) begin
      state_nxt = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok)  state_nxt = S_ACCUM;
        S_ACCUM: if (last_beat) state_nxt = S_HOLD;
        S_HOLD:  if (OUT_READY) state_nxt = S_IDLE;
        default:                state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      result_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else if (ABORT) begin
      // RESULT deliberately survives an abort; only the in-flight burst is dropped.
      for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            len_q      <= LEN;
            beat_cnt_q <= '0;
            for (int i = 0; i < LANES; i++) acc_q[i] <= '0;
          end
        end
        S_ACCUM: begin
          if (beat) begin
            for (int i = 0; i < LANES; i++) acc_q[i] <= sum_nxt[i];
            beat_cnt_q <= cnt_inc;
            if (last_beat) result_q <= sum_flat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_collector.sv
// Directed bench for acc_collector: scoreboard of expected burst sums, immediate-assertion checks.
module tb_acc_collector;
  localparam int DW = 32;
  localparam int LN = 2;
  localparam int LW = 8;

  logic             CLK;
  logic             RST_N;
  logic             START;
  logic [LW-1:0]    LEN;
  logic             ABORT;
  logic             IN_VALID;
  logic             IN_READY;
  logic [LN*DW-1:0] ACC_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [LN*DW-1:0] RESULT;
  logic [LW-1:0]    BEAT_CNT;
  logic             BUSY;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] sb [$];
  logic [63:0] last_result = '0;

  acc_collector #(.DATA_W(DW), .LANES(LN), .LEN_W(LW)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .LEN       (LEN),
    .ABORT     (ABORT),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .ACC_DATA  (ACC_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .RESULT    (RESULT),
    .BEAT_CNT  (BEAT_CNT),
    .BUSY      (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_burst(input logic [LW-1:0] len);
    LEN   = len;
    START = 1'b1;
    tick();
    START = 1'b0;
    LEN   = '0;
  endtask

  task automatic send_beat(input logic [DW-1:0] l0, input logic [DW-1:0] l1);
    int n;
    n        = 0;
    ACC_DATA = {l1, l0};
    IN_VALID = 1'b1;
    while (IN_READY !== 1'b1) begin
      tick();
      n++;
      if (n >= 50) begin
        check("in_ready_timeout", {63'd0, IN_READY}, 64'd1);
        break;
      end
    end
    tick();
    IN_VALID = 1'b0;
  endtask

  task automatic collect(input logic [LW-1:0] exp_cnt);
    int          n;
    logic [63:0] exp;
    n = 0;
    while (OUT_VALID !== 1'b1) begin
      tick();
      n++;
      if (n >= 50) begin
        check("out_valid_timeout", {63'd0, OUT_VALID}, 64'd1);
        break;
      end
    end
    exp = (sb.size() != 0) ? sb.pop_front() : 'x;
    check("result", RESULT, exp);
    check("beat_cnt_hold", {56'd0, BEAT_CNT}, {56'd0, exp_cnt});
    last_result = exp;
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("out_valid_after_xfer", {63'd0, OUT_VALID}, 64'd0);
    check("busy_after_xfer", {63'd0, BUSY}, 64'd0);
    check("result_kept_idle", RESULT, exp);
  endtask

  initial begin
    RST_N     = 1'b0;
    START     = 1'b0;
    LEN       = '0;
    ABORT     = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    ACC_DATA  = '0;
    #1;
    check("rst_in_ready", {63'd0, IN_READY}, 64'd0);
    check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("rst_busy", {63'd0, BUSY}, 64'd0);
    check("rst_result", RESULT, 64'd0);
    check("rst_beat_cnt", {56'd0, BEAT_CNT}, 64'd0);
    #11 RST_N = 1'b1;
    tick();

    // Basic burst, IN_VALID continuously high.
    start_burst(8'd4);
    check("accum_in_ready", {63'd0, IN_READY}, 64'd1);
    check("accum_busy", {63'd0, BUSY}, 64'd1);
    check("accum_cnt0", {56'd0, BEAT_CNT}, 64'd0);
    sb.push_back({32'd100, 32'd10});
    send_beat(32'd1, 32'd10);
    send_beat(32'd2, 32'd20);
    send_beat(32'd3, 32'd30);
    send_beat(32'd4, 32'd40);
    check("latency_out_valid", {63'd0, OUT_VALID}, 64'd1);
    check("hold_in_ready", {63'd0, IN_READY}, 64'd0);
    collect(8'd4);

    // Bubbles on the input, then backpressure on the output.
    start_burst(8'd3);
    for (int i = 0; i < 5; i++) begin
      IN_VALID = (i % 2 == 0);
      ACC_DATA = {32'(100 * (i + 1)), 32'(i + 1)};
      tick();
    end
    IN_VALID = 1'b0;
    check("bubble_out_valid", {63'd0, OUT_VALID}, 64'd1);
    sb.push_back({32'd900, 32'd9});
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", {63'd0, OUT_VALID}, 64'd1);
      check("bp_result_stable", RESULT, {32'd900, 32'd9});
    end
    collect(8'd3);

    // Lane overflow behaviour.
    start_burst(8'd2);
`ifdef ACC_COLLECTOR_SAT_EN
    sb.push_back({32'h8000_0000, 32'h7FFF_FFFF});
    send_beat(32'h7FFF_FFFF, 32'h8000_0000);
    send_beat(32'h0000_0001, 32'hFFFF_FFFF);
`else
    sb.push_back({32'd12, 32'h0000_0001});
    send_beat(32'hFFFF_FFFF, 32'd5);
    send_beat(32'h0000_0002, 32'd7);
`endif
    collect(8'd2);

    // Zero-length START is ignored.
    LEN   = 8'd0;
    START = 1'b1;
    tick();
    START = 1'b0;
    check("len0_busy", {63'd0, BUSY}, 64'd0);
    check("len0_in_ready", {63'd0, IN_READY}, 64'd0);

    // Maximum burst with a stray START in the middle.
    start_burst(8'd255);
    IN_VALID = 1'b1;
    ACC_DATA = {32'd1, 32'd1};
    for (int i = 0; i < 255; i++) begin
      if (i == 100) begin
        START = 1'b1;
        LEN   = 8'd5;
      end
      tick();
      START = 1'b0;
      LEN   = '0;
      if (i == 100) check("start_in_accum_cnt", {56'd0, BEAT_CNT}, 64'd101);
    end
    check("max_out_valid", {63'd0, OUT_VALID}, 64'd1);
    tick();
    IN_VALID = 1'b0;
    check("no_beat_in_hold", {56'd0, BEAT_CNT}, 64'd255);
    sb.push_back({32'd255, 32'd255});
    collect(8'd255);

    // Abort mid-burst with a beat on the input.
    start_burst(8'd4);
    send_beat(32'd7, 32'd8);
    send_beat(32'd9, 32'd10);
    ACC_DATA = {32'd50, 32'd60};
    IN_VALID = 1'b1;
    ABORT    = 1'b1;
    tick();
    ABORT    = 1'b0;
    IN_VALID = 1'b0;
    check("abort_busy", {63'd0, BUSY}, 64'd0);
    check("abort_cnt", {56'd0, BEAT_CNT}, 64'd0);
    check("abort_in_ready", {63'd0, IN_READY}, 64'd0);
    check("abort_result_kept", RESULT, last_result);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_out_valid", {63'd0, OUT_VALID}, 64'd0);
    end

    // Asynchronous reset while holding a result.
    start_burst(8'd2);
    send_beat(32'd11, 32'd12);
    send_beat(32'd13, 32'd14);
    check("pre_reset_hold", {63'd0, OUT_VALID}, 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("arst_result", RESULT, 64'd0);
    check("arst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("arst_busy", {63'd0, BUSY}, 64'd0);
    check("arst_cnt", {56'd0, BEAT_CNT}, 64'd0);
    check("arst_in_ready", {63'd0, IN_READY}, 64'd0);
    #3 RST_N = 1'b1;
    tick();
    start_burst(8'd1);
    sb.push_back({32'd6, 32'd5});
    send_beat(32'd5, 32'd6);
    collect(8'd1);

    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/acc_collector.md
Name: acc_collector

Overview:
Receives the two-lane 32-bit ACC_DATA stream produced by the SIMD processing element and sums it lane-wise over a programmed number of beats. Uses a valid/ready handshake on both input and output. Sits between the processing element and the writeback/result path. Presents one two-lane sum per burst and holds it until the downstream side accepts it.

Parameters:
DATA_W, 32, width of each lane, on input and on output.
LANES, 2, number of independent accumulation lanes; matches ACC_DATA.
LEN_W, 8, width of the burst-length field; sets the maximum burst to 2^LEN_W-1 beats.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
RST_N  input  1  asynchronous, active-low reset.
START  input  1  one-cycle pulse that begins a burst; sampled only in IDLE.
LEN  input  LEN_W  number of beats in the burst; sampled with START.
ABORT  input  1  synchronous abort; forces IDLE and clears accumulators.
IN_VALID  input  1  ACC_DATA beat is valid.
IN_READY  output  1  collector can accept a beat.
ACC_DATA  input  LANES x DATA_W  lane operands from the processing element.
OUT_VALID  output  1  RESULT holds a completed sum.
OUT_READY  input  1  downstream accepts RESULT.
RESULT  output  LANES x DATA_W  per-lane burst sums.
BEAT_CNT  output  LEN_W  beats accepted so far in the current burst.
BUSY  output  1  high in ACCUM or HOLD.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE; accumulators, RESULT, BEAT_CNT, latched length = 0; IN_READY, OUT_VALID, BUSY = 0.
- States: IDLE, ACCUM, HOLD (2-bit encoding; the unused code returns to IDLE).
- IDLE:
  - IN_READY=0, OUT_VALID=0.
  - START=1 with LEN!=0: latch LEN, clear accumulators and BEAT_CNT, go to ACCUM next cycle.
  - START with LEN==0 is ignored; the block stays in IDLE.
- ACCUM:
  - IN_READY=1 (registered; high from the first cycle in ACCUM).
  - Beat = IN_VALID && IN_READY on a rising edge. On a beat: acc[i] <= acc[i] + ACC_DATA[i] for each lane, modulo 2^DATA_W (two's complement wrap); BEAT_CNT increments.
  - Cycles without IN_VALID change nothing.
  - On the beat where BEAT_CNT+1 == latched length: RESULT <= final sums (including that beat), OUT_VALID <= 1, IN_READY <= 0, go to HOLD.
  - Latency: RESULT/OUT_VALID visible the cycle after the last accepted beat.
  - Exactly LEN beats are accepted per burst; no beat is accepted in the cycle the block enters HOLD.
- HOLD:
  - OUT_VALID=1; RESULT and BEAT_CNT held stable.
  - OUT_VALID && OUT_READY: OUT_VALID <= 0, go to IDLE.
  - OUT_READY may stay high; exactly one transfer occurs per burst.
  - RESULT keeps its last value in IDLE until the next completed burst.
- START while in ACCUM or HOLD is ignored.
- A new START is only sampled from the first cycle back in IDLE; no same-cycle HOLD-to-ACCUM turnaround.
- ABORT has priority over all other inputs in every state:
  - Next cycle: IDLE, accumulators and BEAT_CNT = 0, IN_READY=0, OUT_VALID=0.
  - RESULT keeps its previous value.
  - A beat presented in the ABORT cycle is not counted.
- BUSY = (state != IDLE).
- Asynchronous reset during ACCUM or HOLD discards the burst; no partial RESULT is produced.

Optional Feature:
Macro: ACC_COLLECTOR_SAT_EN
- Defined: lane adds are signed and saturating. Positive overflow clamps to 2^(DATA_W-1)-1 (0x7FFFFFFF); negative overflow clamps to -2^(DATA_W-1) (0x80000000). Once a lane is clamped, later beats continue from the clamped value.
- Not defined: plain modulo-2^DATA_W wrap as above; no saturation logic is synthesised.

Test Plan:
- Basic burst: START, LEN=4; beats lane0 = 1,2,3,4 and lane1 = 10,20,30,40 with IN_VALID held high -> OUT_VALID one cycle after the 4th beat, RESULT = {100, 10}, BEAT_CNT=4.
- Backpressure and bubbles: LEN=3, IN_VALID toggled 1,0,1,0,1 -> exactly 3 beats summed. Then hold OUT_READY=0 for 5 cycles -> RESULT stable, OUT_VALID stays 1; on OUT_READY=1 -> IDLE the next cycle.
- Wrap (macro undefined): LEN=2, lane0 = 0xFFFFFFFF, 0x00000002 -> RESULT lane0 = 0x00000001. With ACC_COLLECTOR_SAT_EN: lane0 = 0x7FFFFFFF, 0x00000001 -> 0x7FFFFFFF; lane1 = 0x80000000, 0xFFFFFFFF -> 0x80000000.
- Boundaries: START with LEN=0 -> stays IDLE, IN_READY=0. LEN=255 with 255 beats of value 1 -> RESULT = {255, 255}. START asserted during ACCUM -> ignored, count unaffected.
- ABORT mid-burst: LEN=4, 2 beats accepted, ABORT with IN_VALID=1 -> IDLE next cycle, BEAT_CNT=0, OUT_VALID never asserted, previous RESULT unchanged.
- Async reset: RST_N pulled low mid-cycle in HOLD -> all outputs 0 immediately, without waiting for a clock edge. After release, a fresh LEN=1 burst with {5, 6} -> RESULT = {6, 5}.
